mp_link_ctrl: RTL
=================

MP_LINK_CTRL -- requirements
Module: mp_link_ctrl

Interface
REQ-001 Parameter READY_CHAR, default 8'h52, byte announcing local player ready.
REQ-002 Parameter LOSS_CHAR, default 8'h4C, byte announcing local player lost.
REQ-003 Parameter ACK_CHAR, default 8'h41, byte acknowledging a received LOSS_CHAR.
REQ-004 Parameter RETX_PERIOD, default 1_000_000, cycles between repeated transmissions; minimum 2.
REQ-005 Parameter MAX_RETRIES, default 8, number of LOSS_CHAR sends without ACK before error; minimum 1.
REQ-006 Parameter PEER_TIMEOUT, default 100_000_000, cycles in WAIT_PEER with no READY_CHAR received before error.
REQ-007 Ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-008 Ports: multiplayer in 1, enables the link; player_ready in 1, level, local player waiting; game_over in 1, level, local player lost.
REQ-009 Ports: rx_data in 8, head byte of the UART receive FIFO (first-word fall-through); rx_empty in 1; rd_uart out 1, one-cycle pop.
REQ-010 Ports: tx_data out 8, byte to send; wr_uart out 1, one-cycle push; tx_full in 1.
REQ-011 Ports: game_start out 1, one-cycle pulse; victory out 1, level; link_error out 1, level; state_out out 3, current state encoding.

Function
REQ-012 The FSM SHALL have states IDLE=0, WAIT_PEER=1, PLAYING=2, LOSS_TX=3, LOST=4, WON=5, ERROR=6.
REQ-013 IDLE: move to WAIT_PEER when multiplayer=1 and player_ready=1; otherwise stay.
REQ-014 WAIT_PEER: send READY_CHAR on entry and every RETX_PERIOD cycles; on receipt of READY_CHAR, send one more READY_CHAR, pulse game_start, and go to PLAYING.
REQ-015 WAIT_PEER: go to ERROR after PEER_TIMEOUT cycles with no READY_CHAR; return to IDLE if player_ready or multiplayer drops.
REQ-016 PLAYING: game_over=1 goes to LOSS_TX; received LOSS_CHAR sends ACK_CHAR and goes to WON; in the same cycle, a received LOSS_CHAR takes priority over game_over.
REQ-017 LOSS_TX: send LOSS_CHAR on entry and every RETX_PERIOD cycles; received ACK_CHAR goes to LOST; after MAX_RETRIES sends with no ACK_CHAR, go to ERROR.
REQ-018 LOST and WON SHALL hold until multiplayer=0, then go to IDLE; WON re-sends ACK_CHAR for every further LOSS_CHAR received.
REQ-019 victory SHALL be 1 exactly while in WON; link_error SHALL be 1 exactly while in ERROR; ERROR exits only via rst or multiplayer=0 to IDLE.
REQ-020 Receive: when rx_empty=0, assert rd_uart for one cycle and decode the registered rx_data on the next cycle; keep at least one idle cycle between pops. Bytes not valid in the current state SHALL be popped and discarded.
REQ-021 Transmit: assert wr_uart for one cycle with tx_data valid, only when tx_full=0; if tx_full=1, hold the pending byte until space is free, with no byte lost or duplicated. A newer pending send of the same character replaces an older one.
REQ-022 The retransmit counter SHALL restart on every state entry; the retry count SHALL be saturating and 0 on LOSS_TX entry.
REQ-023 multiplayer=0 in any state SHALL force IDLE on the next cycle with no further transmissions.
REQ-024 game_start latency: one cycle after the cycle in which the READY_CHAR decode occurs.

Reset
REQ-025 On rst, the block SHALL set state IDLE; rd_uart, wr_uart, game_start, victory and link_error 0; tx_data 8'h00; all counters 0; pending transmit cleared.
REQ-026 Reset mid-transmission SHALL not issue wr_uart in the reset cycle or the following cycle.

Structure
REQ-027 A shared package mp_link_pkg SHALL hold the state encoding and the default character constants.
REQ-028 Counter widths SHALL be derived with $clog2 of their parameters.
REQ-029 A single sub-module mp_link_tx_arb SHALL hold the pending-byte register and the tx_full/wr_uart handshake.

Verification
REQ-030 Handshake: multiplayer=1, player_ready=1, peer injects 8'h52 after 50 cycles -> two 8'h52 sent, game_start pulses once, state_out=2.
REQ-031 Loss with ACK: in PLAYING, game_over=1, ACK 8'h41 injected after second send -> exactly two 8'h4C sent, state_out=4, victory=0.
REQ-032 Retry exhaustion: MAX_RETRIES=3, no ACK -> three 8'h4C sent RETX_PERIOD apart, then link_error=1, state_out=6.
REQ-033 Win plus simultaneous events: 8'h4C decoded in the same cycle as game_over=1 -> 8'h41 sent, victory=1; a repeated 8'h4C -> a second 8'h41.
REQ-034 Backpressure: tx_full=1 for 200 cycles during a send -> no wr_uart until release, then exactly one write with the correct byte.
REQ-035 Abort: rst or multiplayer=0 in LOSS_TX -> IDLE, all outputs 0, no further writes.

Source files
------------

// File: rtl/mp_link_pkg.sv
// rtl/mp_link_pkg.sv - shared state encoding and default link characters for mp_link_ctrl
package mp_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PEER = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_LOSS_TX   = 3'd3,
        ST_LOST      = 3'd4,
        ST_WON       = 3'd5,
        ST_ERROR     = 3'd6
    } link_state_t;

    localparam logic [7:0] DEF_READY_CHAR = 8'h52;
    localparam logic [7:0] DEF_LOSS_CHAR  = 8'h4C;
    localparam logic [7:0] DEF_ACK_CHAR   = 8'h41;

    // Bit positions of the per-character send request vector, also the issue priority order
    localparam int TX_READY = 0;
    localparam int TX_ACK   = 1;
    localparam int TX_LOSS  = 2;

endpackage

// File: rtl/mp_link_tx_arb.sv
// rtl/mp_link_tx_arb.sv - pending-byte holding and tx_full/wr_uart handshake for mp_link_ctrl
module mp_link_tx_arb
    import mp_link_pkg::*;
#(
    parameter logic [7:0] READY_CHAR = DEF_READY_CHAR,
    parameter logic [7:0] LOSS_CHAR  = DEF_LOSS_CHAR,
    parameter logic [7:0] ACK_CHAR   = DEF_ACK_CHAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [2:0] send_req,
    input  logic       tx_full,
    output logic [7:0] tx_data,
    output logic       wr_uart
);

    // One pending flag per character: a repeat request of the same character merges into it,
    // while different characters never overwrite each other.
    logic [2:0] pend;
    logic [2:0] grant;

    always_comb begin
        grant   = 3'b000;
        tx_data = 8'h00;
        if (pend[TX_READY]) begin
            grant[TX_READY] = 1'b1;
            tx_data         = READY_CHAR;
        end else if (pend[TX_ACK]) begin
            grant[TX_ACK] = 1'b1;
            tx_data       = ACK_CHAR;
        end else if (pend[TX_LOSS]) begin
            grant[TX_LOSS] = 1'b1;
            tx_data        = LOSS_CHAR;
        end
    end

    assign wr_uart = ~rst & ~flush & ~tx_full & (|pend);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pend <= 3'b000;
        end else begin
            pend <= (pend & ~(grant & {3{wr_uart}})) | send_req;
        end
    end

endmodule

// File: rtl/mp_link_ctrl.sv
// rtl/mp_link_ctrl.sv - two-player UART link: ready handshake, loss/ack exchange, error supervision
module mp_link_ctrl
    import mp_link_pkg::*;
#(
    parameter logic [7:0] READY_CHAR   = DEF_READY_CHAR,
    parameter logic [7:0] LOSS_CHAR    = DEF_LOSS_CHAR,
    parameter logic [7:0] ACK_CHAR     = DEF_ACK_CHAR,
    parameter int         RETX_PERIOD  = 1_000_000,
    parameter int         MAX_RETRIES  = 8,
    parameter int         PEER_TIMEOUT = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       multiplayer,
    input  logic       player_ready,
    input  logic       game_over,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rd_uart,
    output logic [7:0] tx_data,
    output logic       wr_uart,
    input  logic       tx_full,
    output logic       game_start,
    output logic       victory,
    output logic       link_error,
    output logic [2:0] state_out
);

    localparam int RETX_W  = $clog2(RETX_PERIOD);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int PEER_W  = $clog2(PEER_TIMEOUT + 1);
    localparam logic [RETX_W-1:0]  RETX_LAST = RETX_W'(RETX_PERIOD - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [PEER_W-1:0]  PEER_LAST = PEER_W'(PEER_TIMEOUT - 1);

    link_state_t        state, state_next;
    logic [RETX_W-1:0]  retx_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [PEER_W-1:0]  peer_cnt;
    logic [7:0]         rx_byte;
    logic               rx_vld;
    logic               rx_ready, rx_loss, rx_ack;
    logic [2:0]         send_req;
    logic               start_next;

    assign rx_ready = rx_vld && (rx_byte == READY_CHAR);
    assign rx_loss  = rx_vld && (rx_byte == LOSS_CHAR);
    assign rx_ack   = rx_vld && (rx_byte == ACK_CHAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Periodic sends fire whenever retx_cnt is zero, which covers both state entry and each wrap.
    always_comb begin
        state_next = state;
        send_req   = 3'b000;
        start_next = 1'b0;
        if (!multiplayer) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (player_ready) state_next = ST_WAIT_PEER;
                ST_WAIT_PEER: begin
                    if (!player_ready) begin
                        state_next = ST_IDLE;
                    end else if (rx_ready) begin
                        send_req[TX_READY] = 1'b1;
                        start_next         = 1'b1;
                        state_next         = ST_PLAYING;
                    end else if (peer_cnt == PEER_LAST) begin
                        state_next = ST_ERROR;
                    end else if (retx_cnt == '0) begin
                        send_req[TX_READY] = 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (rx_loss) begin
                        send_req[TX_ACK] = 1'b1;
                        state_next       = ST_WON;
                    end else if (game_over) begin
                        state_next = ST_LOSS_TX;
                    end
                end
                ST_LOSS_TX: begin
                    if (rx_ack) begin
                        state_next = ST_LOST;
                    end else if (retx_cnt == '0) begin
                        if (retry_cnt == RETRY_MAX) state_next = ST_ERROR;
                        else                        send_req[TX_LOSS] = 1'b1;
                    end
                end
                ST_WON:   if (rx_loss) send_req[TX_ACK] = 1'b1;
                ST_LOST:  state_next = ST_LOST;
                ST_ERROR: state_next = ST_ERROR;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retx_cnt   <= '0;
            retry_cnt  <= '0;
            peer_cnt   <= '0;
            rx_byte    <= 8'h00;
            rx_vld     <= 1'b0;
            rd_uart    <= 1'b0;
            game_start <= 1'b0;
        end else begin
            // Pop at most every other cycle; the popped head is decoded the cycle after the pop.
            rd_uart    <= ~rx_empty & ~rd_uart;
            rx_vld     <= rd_uart;
            if (rd_uart) rx_byte <= rx_data;
            game_start <= start_next;
            if (state_next != state) begin
                retx_cnt  <= '0;
                retry_cnt <= '0;
                peer_cnt  <= '0;
            end else begin
                retx_cnt <= (retx_cnt == RETX_LAST) ? '0 : retx_cnt + RETX_W'(1);
                if (state == ST_WAIT_PEER && peer_cnt != PEER_LAST)
                    peer_cnt <= peer_cnt + PEER_W'(1);
                if (send_req[TX_LOSS] && retry_cnt != RETRY_MAX)
                    retry_cnt <= retry_cnt + RETRY_W'(1);
            end
        end
    end

    mp_link_tx_arb #(
        .READY_CHAR (READY_CHAR),
        .LOSS_CHAR  (LOSS_CHAR),
        .ACK_CHAR   (ACK_CHAR)
    ) u_tx_arb (
        .clk      (clk),
        .rst      (rst),
        .flush    (~multiplayer),
        .send_req (send_req),
        .tx_full  (tx_full),
        .tx_data  (tx_data),
        .wr_uart  (wr_uart)
    );

    assign victory    = (state == ST_WON);
    assign link_error = (state == ST_ERROR);
    assign state_out  = state;

endmodule
